// File: rtl/seqdet_bit_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module : seqdet_bit_feeder_pkg
//  Brief  : Shared state encodings and default sizing for the bit feeder.
//  Rev    : 1.0  initial release
// ============================================================================
package seqdet_bit_feeder_pkg;

    // Feeder FSM state encodings (2-bit)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Default sizing of the serializer
    localparam int c_DEF_WIDTH      = 8;
    localparam int c_DEF_TICK_DIV   = 25;
    localparam int c_DEF_SAMPLE_DIV = 16;

endpackage
`default_nettype wire

// File: rtl/seqdet_bit_feeder_btn_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module : seqdet_bit_feeder_btn_edge_sync
//  Brief  : Two-flop button sampler with a registered single-cycle rising
//           edge pulse. Samples only when i_strobe is high.
//  Rev    : 1.0  initial release
// ============================================================================
module seqdet_bit_feeder_btn_edge_sync
    import seqdet_bit_feeder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_strobe,
    input  logic i_btn,
    output logic o_edge
);

    logic r_q1;
    logic r_q2;
    logic r_edge;

    // Sample the raw button on the strobe and register one pulse per rising edge.
    // Gating the pulse with the strobe keeps it one clk wide even when the
    // sample period is many cycles long.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q1   <= 1'b0;
            r_q2   <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            if (i_strobe) begin
                r_q1 <= i_btn;
                r_q2 <= r_q1;
            end
            r_edge <= i_strobe & r_q1 & ~r_q2;
        end
    end

    assign o_edge = r_edge;

endmodule
`default_nettype wire

// File: rtl/seqdet_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module : seqdet_bit_feeder
//  Brief  : Captures a switch pattern on a start press and serializes it LSB
//           first, one bit per prescaler tick, to the sequence detector.
//  Rev    : 1.0  initial release
// ============================================================================
module seqdet_bit_feeder
    import seqdet_bit_feeder_pkg::*;
#(
    parameter int WIDTH      = c_DEF_WIDTH,
    parameter int TICK_DIV   = c_DEF_TICK_DIV,
    parameter int SAMPLE_DIV = c_DEF_SAMPLE_DIV
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_sw,
    input  logic             i_btn_start,
    input  logic             i_btn_abort,
    output logic             o_x,
    output logic             o_bit_valid,
    output logic             o_fsm_reset,
    output logic             o_busy,
    output logic             o_done,
    output logic [3:0]       o_bit_idx,
    output logic [WIDTH-1:0] o_led_onehot
);

    localparam logic [3:0] c_IDX_NONE = 4'(WIDTH);
    localparam logic [3:0] c_IDX_LAST = 4'(WIDTH - 1);

    logic                w_sample;
    logic                w_start_ed;
    logic                w_abort_ed;
    logic                w_tick;
    logic                w_pre_clr;
    logic [TICK_DIV-1:0] r_pre;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [WIDTH-1:0]    r_shadow;
    logic [WIDTH-1:0]    w_shadow_nxt;
    logic [3:0]          r_idx;
    logic [3:0]          w_idx_nxt;
    logic                r_x;
    logic                w_x_nxt;

    // ------------------------------------------------------------------
    // Button sample strobe: every cycle, or when the low SAMPLE_DIV bits
    // of a free-running counter are all ones.
    // ------------------------------------------------------------------
    generate
        if (SAMPLE_DIV == 0) begin : g_sample_always
            assign w_sample = 1'b1;
        end else begin : g_sample_div
            logic [SAMPLE_DIV-1:0] r_div;

            // Free-running sample divider
            always_ff @(posedge clk) begin
                if (reset) r_div <= '0;
                else       r_div <= r_div + SAMPLE_DIV'(1);
            end

            assign w_sample = &r_div;
        end
    endgenerate

    seqdet_bit_feeder_btn_edge_sync u_start_sync (
        .clk      (clk),
        .reset    (reset),
        .i_strobe (w_sample),
        .i_btn    (i_btn_start),
        .o_edge   (w_start_ed)
    );

    seqdet_bit_feeder_btn_edge_sync u_abort_sync (
        .clk      (clk),
        .reset    (reset),
        .i_strobe (w_sample),
        .i_btn    (i_btn_abort),
        .o_edge   (w_abort_ed)
    );

    // Bit-period prescaler, restarted on every entry into SHIFT so the
    // first bit lasts a full period.
    always_ff @(posedge clk) begin
        if (reset || w_pre_clr) r_pre <= '0;
        else                    r_pre <= r_pre + TICK_DIV'(1);
    end

    assign w_tick = &r_pre;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state, capture and index logic; abort overrides start and tick
    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_idx_nxt    = r_idx;
        w_pre_clr    = 1'b0;
        w_x_nxt      = 1'b0;
        if (w_abort_ed) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = c_IDX_NONE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ed) begin
                        w_shadow_nxt = i_sw;
                        w_idx_nxt    = 4'd0;
                        w_state_nxt  = ST_SHIFT;
                        w_pre_clr    = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (r_idx == c_IDX_LAST) begin
                            w_idx_nxt   = c_IDX_NONE;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = c_IDX_NONE;
                end
            endcase
        end
        // x is registered, so it is selected from the next-cycle shadow/index
        if (w_state_nxt == ST_SHIFT) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (4'(i) == w_idx_nxt) w_x_nxt = w_shadow_nxt[i];
            end
        end
    end

    // Shadow pattern, bit index and serial output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_idx    <= c_IDX_NONE;
            r_x      <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            r_idx    <= w_idx_nxt;
            r_x      <= w_x_nxt;
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        o_fsm_reset  = (r_state == ST_IDLE);
        o_busy       = (r_state == ST_SHIFT);
        o_done       = (r_state == ST_DONE);
        o_bit_valid  = (r_state == ST_SHIFT) && w_tick && !w_abort_ed;
        o_led_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((r_state == ST_SHIFT) && (r_idx == 4'(WIDTH - 1 - i)))
                o_led_onehot[i] = 1'b1;
        end
    end

    assign o_x       = r_x;
    assign o_bit_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_seqdet_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module : tb_seqdet_bit_feeder
//  Brief  : Self-checking bench for seqdet_bit_feeder (WIDTH=8, TICK_DIV=2,
//           SAMPLE_DIV=0) against a run-based reference model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_seqdet_bit_feeder;

    localparam int W    = 8;
    localparam int BITP = 4;   // 2**TICK_DIV cycles per bit

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sw;
    logic        btn_start;
    logic        btn_abort;
    logic        x, bit_valid, fsm_reset, busy, done;
    logic [3:0]  bit_idx;
    logic [7:0]  led_onehot;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a run is described by its start cycle and captured
    // pattern; everything else follows from elapsed time.
    logic [3:0]  m_hs;
    logic [3:0]  m_ha;
    bit          m_active;
    int          m_cyc;
    int          m_start;
    logic [7:0]  m_pat;
    logic [16:0] m_exp;

    wire [16:0] w_obs = {x, bit_valid, fsm_reset, busy, done, bit_idx, led_onehot};

    always #5 clk = ~clk;

    seqdet_bit_feeder #(
        .WIDTH      (8),
        .TICK_DIV   (2),
        .SAMPLE_DIV (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_sw         (sw),
        .i_btn_start  (btn_start),
        .i_btn_abort  (btn_abort),
        .o_x          (x),
        .o_bit_valid  (bit_valid),
        .o_fsm_reset  (fsm_reset),
        .o_busy       (busy),
        .o_done       (done),
        .o_bit_idx    (bit_idx),
        .o_led_onehot (led_onehot)
    );

    task automatic model_expect();
        int         kk;
        int         ph;
        bit         sh;
        bit         ab_vis;
        logic [7:0] led_top;
        led_top = 8'h80;
        kk      = (m_cyc - m_start) / BITP;
        ph      = (m_cyc - m_start) % BITP;
        sh      = m_active && (kk < W);
        ab_vis  = m_ha[1] & ~m_ha[2];
        m_exp = {sh ? m_pat[kk] : 1'b0,
                 sh && (ph == BITP - 1) && !ab_vis,
                 !m_active,
                 sh,
                 m_active && (kk >= W),
                 sh ? 4'(kk) : 4'd8,
                 sh ? (led_top >> kk) : 8'h00};
    endtask

    task automatic model_update();
        bit st_ed;
        bit ab_ed;
        int k_old;
        m_hs = {m_hs[2:0], btn_start};
        m_ha = {m_ha[2:0], btn_abort};
        if (reset) begin
            m_hs = '0; m_ha = '0; m_active = 0; m_cyc = 0; m_start = 0; m_pat = '0;
        end else begin
            // Edges seen by the feeder in the cycle that just ended
            st_ed = m_hs[2] & ~m_hs[3];
            ab_ed = m_ha[2] & ~m_ha[3];
            k_old = (m_cyc - m_start) / BITP;
            if (ab_ed) begin
                m_active = 0;
            end else if (st_ed && (!m_active || k_old >= W)) begin
                m_active = 1;
                m_start  = m_cyc + 1;
                m_pat    = sw;
            end
            m_cyc++;
        end
        model_expect();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; sw = 8'h00; btn_start = 1'b0; btn_abort = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_checks++; if (fsm_reset !== 1'b1) begin n_errors++; $display("FAIL reset_fsm_reset got=%b exp=1", fsm_reset); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (bit_idx !== 4'd8) begin n_errors++; $display("FAIL reset_bit_idx got=%0d exp=8", bit_idx); end
        n_checks++; if (led_onehot !== 8'h00) begin n_errors++; $display("FAIL reset_led got=%h exp=00", led_onehot); end
        n_checks++; if (x !== 1'b0) begin n_errors++; $display("FAIL reset_x got=%b exp=0", x); end
        n_checks++; if (bit_valid !== 1'b0) begin n_errors++; $display("FAIL reset_bit_valid got=%b exp=0", bit_valid); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (w_obs !== m_exp) begin n_errors++; $display("FAIL post_reset got=%h exp=%h", w_obs, m_exp); end
        end
    endtask

    task automatic test_serialize();
        logic [7:0] seq;
        logic [7:0] pat;
        int         nbv;
        int         first_busy;
        int         last_bv;
        int         first_bv;
        pat = 8'b1011_0010;
        seq = '0; nbv = 0; first_busy = -1; last_bv = -1; first_bv = -1;
        sw = pat; btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 12) sw = 8'hFF;
            step();
            n_checks++; if (w_obs !== m_exp) begin n_errors++; $display("FAIL serialize cyc=%0d got=%h exp=%h", i, w_obs, m_exp); end
            if (busy && first_busy < 0) begin
                first_busy = i;
                n_checks++; if (led_onehot !== 8'h80) begin n_errors++; $display("FAIL led_bit0 got=%h exp=80", led_onehot); end
            end
            if (bit_valid) begin
                if (nbv < 8) seq[nbv] = x;
                if (first_bv < 0) first_bv = i;
                if (last_bv >= 0) begin
                    n_checks++; if (i - last_bv !== 4) begin n_errors++; $display("FAIL strobe_spacing got=%0d exp=4", i - last_bv); end
                end
                last_bv = i;
                nbv++;
            end
        end
        n_checks++; if (nbv !== 8) begin n_errors++; $display("FAIL strobe_count got=%0d exp=8", nbv); end
        n_checks++; if (seq !== pat) begin n_errors++; $display("FAIL stream got=%b exp=%b", seq, pat); end
        n_checks++; if (first_bv - first_busy !== 3) begin n_errors++; $display("FAIL first_bit_latency got=%0d exp=3", first_bv - first_busy); end
        n_checks++; if (done !== 1'b1 || bit_idx !== 4'd8) begin n_errors++; $display("FAIL end_done got=%b/%0d exp=1/8", done, bit_idx); end
    endtask

    task automatic test_start_while_busy();
        int nbv;
        int idx_at_busy;
        nbv = 0; idx_at_busy = -1;
        sw = 8'h5A; btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        for (int i = 0; i < 45; i++) begin
            btn_start = (i >= 12 && i < 14);   // second press mid-run
            step();
            n_checks++; if (w_obs !== m_exp) begin n_errors++; $display("FAIL busy_press cyc=%0d got=%h exp=%h", i, w_obs, m_exp); end
            if (bit_valid) nbv++;
        end
        n_checks++; if (nbv !== 8) begin n_errors++; $display("FAIL busy_press_strobes got=%0d exp=8", nbv); end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL busy_press_done got=%b exp=1", done); end
        // Press again in DONE: new run from bit 0
        sw = 8'hC3; btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        for (int i = 0; i < 10 && idx_at_busy < 0; i++) begin
            step();
            n_checks++; if (w_obs !== m_exp) begin n_errors++; $display("FAIL done_restart cyc=%0d got=%h exp=%h", i, w_obs, m_exp); end
            if (busy) idx_at_busy = int'(bit_idx);
        end
        n_checks++; if (idx_at_busy !== 0) begin n_errors++; $display("FAIL done_restart_idx got=%0d exp=0", idx_at_busy); end
    endtask

    task automatic test_abort();
        int nbv;
        int nbusy;
        nbv = 0; nbusy = 0;
        for (int g = 0; g < 60 && bit_idx !== 4'd3; g++) begin
            step();
            n_checks++; if (w_obs !== m_exp) begin n_errors++; $display("FAIL abort_wait got=%h exp=%h", w_obs, m_exp); end
        end
        n_checks++; if (bit_idx !== 4'd3) begin n_errors++; $display("FAIL abort_reach_idx3 got=%0d exp=3", bit_idx); end
        btn_abort = 1'b1;
        step();
        btn_abort = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++; if (w_obs !== m_exp) begin n_errors++; $display("FAIL abort cyc=%0d got=%h exp=%h", i, w_obs, m_exp); end
            if (bit_valid) nbv++;
        end
        n_checks++; if (nbv !== 0) begin n_errors++; $display("FAIL abort_strobes got=%0d exp=0", nbv); end
        n_checks++; if (fsm_reset !== 1'b1 || bit_idx !== 4'd8) begin n_errors++; $display("FAIL abort_idle got=%b/%0d exp=1/8", fsm_reset, bit_idx); end
        // Abort and start pressed together: abort wins
        btn_abort = 1'b1; btn_start = 1'b1;
        step();
        btn_abort = 1'b0; btn_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++; if (w_obs !== m_exp) begin n_errors++; $display("FAIL abort_start cyc=%0d got=%h exp=%h", i, w_obs, m_exp); end
            if (busy) nbusy++;
        end
        n_checks++; if (nbusy !== 0 || fsm_reset !== 1'b1) begin n_errors++; $display("FAIL abort_start_idle got=%0d/%b exp=0/1", nbusy, fsm_reset); end
    endtask

    task automatic test_level_hold();
        int   nrise;
        logic prev_busy;
        nrise = 0; prev_busy = busy;
        sw = 8'h3C;
        for (int i = 0; i < 60; i++) begin
            btn_start = (i < 50);
            step();
            n_checks++; if (w_obs !== m_exp) begin n_errors++; $display("FAIL level_hold cyc=%0d got=%h exp=%h", i, w_obs, m_exp); end
            if (busy && !prev_busy) begin
                nrise++;
                n_checks++; if (led_onehot !== 8'h80) begin n_errors++; $display("FAIL level_led got=%h exp=80", led_onehot); end
            end
            prev_busy = busy;
        end
        btn_start = 1'b0;
        n_checks++; if (nrise !== 1) begin n_errors++; $display("FAIL level_runs got=%0d exp=1", nrise); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
            btn_abort = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
            step();
            n_checks++; if (w_obs !== m_exp) begin n_errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, w_obs, m_exp); end
        end
        btn_start = 1'b0; btn_abort = 1'b0;
    endtask

    initial begin
        m_hs = '0; m_ha = '0; m_active = 0; m_cyc = 0; m_start = 0; m_pat = '0; m_exp = '0;
        reset = 1'b1; sw = '0; btn_start = 1'b0; btn_abort = 1'b0;
        @(negedge clk);
        test_reset();
        test_serialize();
        test_start_while_busy();
        test_abort();
        test_level_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
